// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: boot-sequencer states, default
// array index widths and the byte written by the RAM clear sweep.
package mem_responder_pkg;

    localparam int ROM_AW_DEFAULT = 12;
    localparam int RAM_AW_DEFAULT = 12;
    localparam int ADDR_W         = 20;
    localparam int DATA_W         = 8;

    localparam logic [DATA_W-1:0] NOP_CLEAR_BYTE = 8'h00;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_responder_byte_ram.sv
// Single-clock byte array with one registered read-first read port and one
// write port; rd_clr forces the read register to zero on the edge.
module mem_responder_byte_ram
    import mem_responder_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              rd_clr,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reading through a register alongside the NBA write gives read-first order.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: ROM/RAM arrays behind the core's byte ports plus a
// boot sequencer that clears RAM, loads the ROM image and releases core reset.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | sweep 8'h00 through every RAM index, one per cycle
// ST_LOAD  | accept ROM image bytes from index 0 until last or full
// ST_RUN   | core out of reset, core ports serviced
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEFAULT,
    parameter int RAM_AW = RAM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              core_rst,
    input  logic              rom_en,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_data,
    input  logic              ram_rd_en,
    input  logic [ADDR_W-1:0] ram_rd_addr,
    output logic [DATA_W-1:0] ram_rd_data,
    input  logic              ram_wr_en,
    input  logic [ADDR_W-1:0] ram_wr_addr,
    input  logic [DATA_W-1:0] ram_wr_data
);

    state_e              state_q;
    state_e              state_d;
    logic [RAM_AW-1:0]   clr_idx_q;
    logic [ROM_AW-1:0]   load_idx_q;
    logic                load_fire;
    logic                run_active;
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;
    logic                unused_addr_hi;

    assign load_ready = (state_q == ST_LOAD) && !rst;
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_idx_q  <= '0;
            load_idx_q <= '0;
            core_rst   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clr_idx_q <= clr_idx_q + RAM_AW'(1);
            end
            if (load_fire) begin
                load_idx_q <= load_idx_q + ROM_AW'(1);
            end
            core_rst <= (state_d != ST_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (&clr_idx_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_fire && (load_last || (&load_idx_q))) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
    end

    // RAM write port belongs to the clear sweep in CLEAR and to the core in RUN.
    always_comb begin
        run_active = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = clr_idx_q;
        ram_wdata  = NOP_CLEAR_BYTE;
        case (state_q)
            ST_CLEAR: ram_we = !rst;
            ST_RUN: begin
                run_active = !rst;
                ram_we     = ram_wr_en && !rst;
                ram_waddr  = ram_wr_addr[RAM_AW-1:0];
                ram_wdata  = ram_wr_data;
            end
            default: ;
        endcase
    end

    mem_responder_byte_ram #(.AW(ROM_AW)) u_rom (
        .clk     (clk),
        .rd_clr  (!run_active),
        .rd_en   (rom_en),
        .rd_addr (rom_addr[ROM_AW-1:0]),
        .rd_data (rom_data),
        .wr_en   (load_fire),
        .wr_addr (load_idx_q),
        .wr_data (load_data)
    );

    mem_responder_byte_ram #(.AW(RAM_AW)) u_ram (
        .clk     (clk),
        .rd_clr  (!run_active),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr[RAM_AW-1:0]),
        .rd_data (ram_rd_data),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata)
    );

    // Address bits above the index width alias by design.
    assign unused_addr_hi = ^{rom_addr[ADDR_W-1:ROM_AW],
                              ram_rd_addr[ADDR_W-1:RAM_AW],
                              ram_wr_addr[ADDR_W-1:RAM_AW]};

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (4-bit ROM/RAM indices): each stimulus
// cycle pushes the reference model's expected outputs, a monitor compares them.
module tb_mem_responder;

    localparam int AW = 4;
    localparam int N  = 16;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        core_rst;
    logic        rom_en;
    logic [19:0] rom_addr;
    logic [7:0]  rom_data;
    logic        ram_rd_en;
    logic [19:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic        ram_wr_en;
    logic [19:0] ram_wr_addr;
    logic [7:0]  ram_wr_data;

    mem_responder #(.ROM_AW(AW), .RAM_AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .core_rst    (core_rst),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] rom;
        logic [7:0] ram;
        bit         rom_chk;
        bit         ram_chk;
        bit         lr;
        bit         cr;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: phase 0 = clearing, 1 = loading, 2 = running.
    logic [7:0] rom_m [N];
    bit         rom_k [N];
    logic [7:0] ram_m [N];
    int         phase  = 0;
    int         clr_n  = 0;
    int         ld_n   = 0;
    logic [7:0] rom_out = 8'h00;
    logic [7:0] ram_out = 8'h00;
    bit         rom_ok = 0;
    bit         ram_ok = 0;

    task automatic check(input string tag, input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s/%s: got %02h expected %02h", tag, name, act, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, advance the model to what
    // the next rising edge should produce, queue it, then wait a full cycle.
    task automatic step(input bit r, input bit lv, input logic [7:0] ld, input bit ll,
                        input bit re, input logic [19:0] ra,
                        input bit rde, input logic [19:0] rda,
                        input bit we, input logic [19:0] wa, input logic [7:0] wd,
                        input string t);
        exp_t e;
        rst = r; load_valid = lv; load_data = ld; load_last = ll;
        rom_en = re; rom_addr = ra; ram_rd_en = rde; ram_rd_addr = rda;
        ram_wr_en = we; ram_wr_addr = wa; ram_wr_data = wd;
        if (r) begin
            phase = 0; clr_n = 0; ld_n = 0;
            rom_out = 8'h00; ram_out = 8'h00; rom_ok = 1; ram_ok = 1;
        end else if (phase == 0) begin
            ram_m[clr_n] = 8'h00;
            clr_n++;
            if (clr_n == N) phase = 1;
            rom_out = 8'h00; ram_out = 8'h00; rom_ok = 1; ram_ok = 1;
        end else if (phase == 1) begin
            if (lv) begin
                rom_m[ld_n] = ld;
                rom_k[ld_n] = 1;
                ld_n++;
                if (ll || ld_n == N) phase = 2;
            end
            rom_out = 8'h00; ram_out = 8'h00; rom_ok = 1; ram_ok = 1;
        end else begin
            if (re) begin
                rom_out = rom_m[ra % N];
                rom_ok  = rom_k[ra % N];
            end
            if (rde) begin
                ram_out = ram_m[rda % N];
                ram_ok  = 1;
            end
            if (we) ram_m[wa % N] = wd;
        end
        e.due = cyc + 1; e.rom = rom_out; e.ram = ram_out;
        e.rom_chk = rom_ok; e.ram_chk = ram_ok;
        e.lr = (phase == 1); e.cr = (phase != 2); e.tag = t;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input string t);
        step(0, 0, 8'h00, 0, 0, 20'h0, 0, 20'h0, 0, 20'h0, 8'h00, t);
    endtask

    task automatic load(input logic [7:0] d, input bit last, input string t);
        step(0, 1, d, last, 0, 20'h0, 0, 20'h0, 0, 20'h0, 8'h00, t);
    endtask

    task automatic rom_rd(input logic [19:0] a, input string t);
        step(0, 0, 8'h00, 0, 1, a, 0, 20'h0, 0, 20'h0, 8'h00, t);
    endtask

    task automatic ram_rw(input bit rde, input logic [19:0] rda, input bit we,
                          input logic [19:0] wa, input logic [7:0] wd, input string t);
        step(0, 0, 8'h00, 0, 0, 20'h0, rde, rda, we, wa, wd, t);
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #2;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.due != cyc) begin
                check(mon_e.tag, "late_check", 8'(mon_e.due), 8'(cyc));
            end else begin
                check(mon_e.tag, "load_ready", {7'd0, load_ready}, {7'd0, mon_e.lr});
                check(mon_e.tag, "core_rst", {7'd0, core_rst}, {7'd0, mon_e.cr});
                if (mon_e.rom_chk) check(mon_e.tag, "rom_data", rom_data, mon_e.rom);
                if (mon_e.ram_chk) check(mon_e.tag, "ram_rd_data", ram_rd_data, mon_e.ram);
            end
        end
    end

    initial begin
        rst = 1; load_valid = 0; load_data = 0; load_last = 0;
        rom_en = 0; rom_addr = 0; ram_rd_en = 0; ram_rd_addr = 0;
        ram_wr_en = 0; ram_wr_addr = 0; ram_wr_data = 0;
        @(negedge clk);

        // Boot with a short image terminated by load_last.
        step(1, 0, 8'h00, 0, 0, 20'h0, 0, 20'h0, 0, 20'h0, 8'h00, "reset");
        repeat (N) idle("clear");
        load(8'hB8, 0, "boot_ld0");
        load(8'h34, 0, "boot_ld1");
        load(8'h12, 1, "boot_last");
        rom_rd(20'hFFFF1, "rom_alias");
        rom_rd(20'h00000, "rom_idx0");
        idle("rom_hold");

        ram_rw(0, 20'h0, 1, 20'h00003, 8'hA5, "ram_wr3");
        ram_rw(1, 20'h00013, 0, 20'h0, 8'h00, "ram_alias_rd");
        ram_rw(1, 20'h00007, 0, 20'h0, 8'h00, "ram_cleared");
        ram_rw(0, 20'h0, 1, 20'h00005, 8'h11, "coll_pre");
        ram_rw(1, 20'h00005, 1, 20'h00005, 8'h22, "coll_rdfirst");
        ram_rw(1, 20'h00005, 0, 20'h0, 8'h00, "coll_after");
        load(8'hEE, 1, "run_drop_load");

        // Partial load interrupted by reset, then a full reload.
        step(1, 0, 8'h00, 0, 0, 20'h0, 0, 20'h0, 0, 20'h0, 8'h00, "reset2");
        repeat (N) idle("clear2");
        load(8'hAA, 0, "part_ld0");
        load(8'hBB, 0, "part_ld1");
        step(1, 0, 8'h00, 0, 0, 20'h0, 0, 20'h0, 0, 20'h0, 8'h00, "reset_midload");
        repeat (N) idle("clear3");
        step(0, 0, 8'h00, 0, 1, 20'h00001, 1, 20'h00003, 1, 20'h00002, 8'hFF, "gate_load");
        for (int i = 0; i < N; i++) load(8'(i), 0, "full_ld");
        load(8'hEE, 0, "load_17th");
        rom_rd(20'h00000, "rom0_after_full");
        rom_rd(20'h00001, "rom1_reloaded");
        rom_rd(20'h0000F, "rom_top");
        ram_rw(1, 20'h00002, 0, 20'h0, 8'h00, "gate_ram2");

        // Random traffic on all three ports at once.
        for (int i = 0; i < 400; i++) begin
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 20'($urandom_range(0, 20'hFFFFF)),
                 1'($urandom_range(0, 1)), 20'($urandom_range(0, 20'hFFFFF)),
                 1'($urandom_range(0, 1)), 20'($urandom_range(0, 20'hFFFFF)),
                 8'($urandom), "random");
        end
        idle("drain");

        @(posedge clk);
        #3;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
